ln_var_rsqrt: RTL and testbench

LN_VAR_RSQRT -- requirements
Module: ln_var_rsqrt

---
 rtl/ln_var_rsqrt_pkg.sv | 32 +++
 rtl/ln_rsqrt_fifo.sv | 57 +++++
 rtl/ln_var_rsqrt.sv | 183 ++++++++++++++++++
 tb/tb_ln_var_rsqrt.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/ln_var_rsqrt_pkg.sv
// rtl/ln_var_rsqrt_pkg.sv - shared defaults, engine states and width helpers for ln_var_rsqrt
package ln_var_rsqrt_pkg;

    localparam int LN_IN_DW  = 40;
    localparam int LN_OUT_DW = 16;
    localparam int LN_K      = 16;
    localparam int LN_EPS    = 1;
    localparam int LN_DEPTH  = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SQRT,
        DIV,
        OUT
    } eng_state_e;

    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

    // Counter must reach the longer of the two iteration phases.
    function automatic int cnt_width(input int in_dw, input int k);
        int n;
        n = (in_dw / 2 > k + 1) ? in_dw / 2 : k + 1;
        return $clog2(n + 1);
    endfunction

    localparam int LN_PTR_W = ptr_width(LN_DEPTH);
    localparam int LN_CNT_W = cnt_width(LN_IN_DW, LN_K);

endpackage

// File: rtl/ln_rsqrt_fifo.sv
// rtl/ln_rsqrt_fifo.sv - register-based input FIFO with count, full and empty
module ln_rsqrt_fifo
    import ln_var_rsqrt_pkg::*;
#(
    parameter int  DW    = LN_IN_DW,
    parameter int  DEPTH = LN_DEPTH,
    localparam int PW    = ptr_width(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr_i,
    input  logic          wr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          rd_i,
    output logic [DW-1:0] rdata_o,
    output logic [PW:0]   count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [PW-1:0] wptr_q;
    logic [PW-1:0] rptr_q;
    logic [PW:0]   cnt_q;
    logic          wr_ok;
    logic          rd_ok;

    assign full_o  = (cnt_q == (PW+1)'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign count_o = cnt_q;
    assign rdata_o = mem_q[rptr_q];

    // A write into a full FIFO is still taken when a pop frees a slot this cycle.
    assign wr_ok = wr_i & (~full_o | rd_i);
    assign rd_ok = rd_i & ~empty_o;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else if (clr_i) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (wr_ok) wptr_q <= wptr_q + PW'(1);
            if (rd_ok) rptr_q <= rptr_q + PW'(1);
            cnt_q <= cnt_q + (PW+1)'(wr_ok) - (PW+1)'(rd_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (wr_ok) mem_q[wptr_q] <= wdata_i;
    end

endmodule

// File: rtl/ln_var_rsqrt.sv
// rtl/ln_var_rsqrt.sv - buffered 1/sqrt(var+eps) engine: bit-serial sqrt then bit-serial divide
module ln_var_rsqrt
    import ln_var_rsqrt_pkg::*;
#(
    parameter int IN_DW  = LN_IN_DW,
    parameter int OUT_DW = LN_OUT_DW,
    parameter int K      = LN_K,
    parameter int EPS    = LN_EPS,
    parameter int DEPTH  = LN_DEPTH
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clr,
    input  logic              in_vld,
    input  logic [IN_DW-1:0]  in_dat,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [OUT_DW-1:0] out_dat,
    output logic              ovf
);

    localparam int HW    = IN_DW / 2;
    localparam int RW    = HW + 2;
    localparam int QW    = K + 1;
    localparam int SW    = (QW > OUT_DW) ? QW : OUT_DW;
    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = cnt_width(IN_DW, K);

    function automatic logic [OUT_DW-1:0] sat_q(input logic [QW-1:0] q);
        logic [SW-1:0] qe;
        logic [SW-1:0] mx;
        qe = SW'(q);
        mx = SW'({OUT_DW{1'b1}});
        return (qe > mx) ? {OUT_DW{1'b1}} : OUT_DW'(qe);
    endfunction

    eng_state_e        state_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              out_vld_q;
    logic [OUT_DW-1:0] out_dat_q;
    logic              ovf_q;

    logic [IN_DW-1:0]  op_q;
    logic [IN_DW-1:0]  sh_q;
    logic [RW-1:0]     rem_q;
    logic [HW-1:0]     root_q;
    logic [HW-1:0]     drem_q;
    logic [QW-2:0]     quo_q;

    logic [IN_DW-1:0]  fifo_rdata;
    logic [PTR_W:0]    fifo_cnt;
    logic              fifo_full;
    logic              fifo_empty;
    logic              fifo_wr;
    logic              fifo_rd;
    logic              pop;
    logic              bypass;
    logic              drop;
    logic [IN_DW-1:0]  head;
    logic [IN_DW-1:0]  v_prep;

    // An idle engine takes a sample straight off the input when nothing is queued.
    assign pop     = (state_q == IDLE) & ~clr & (~fifo_empty | in_vld);
    assign bypass  = pop & (fifo_cnt == '0);
    assign head    = (fifo_cnt == '0) ? in_dat : fifo_rdata;
    assign fifo_wr = in_vld & ~clr & ~bypass;
    assign fifo_rd = pop & ~fifo_empty;
    assign drop    = in_vld & ~clr & ~bypass & fifo_full & ~fifo_rd;

    assign v_prep  = op_q[IN_DW-1] ? IN_DW'(EPS) : op_q + IN_DW'(EPS);

    ln_rsqrt_fifo #(
        .DW    (IN_DW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr_i   (clr),
        .wr_i    (fifo_wr),
        .wdata_i (in_dat),
        .rd_i    (fifo_rd),
        .rdata_o (fifo_rdata),
        .count_o (fifo_cnt),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    logic [RW+1:0] rem_sh;
    logic [RW+1:0] trial;
    logic          sq_ge;
    logic [RW-1:0] rem_d;

    assign rem_sh = {rem_q, sh_q[IN_DW-1 -: 2]};
    assign trial  = {2'b00, root_q, 2'b01};
    assign sq_ge  = (rem_sh >= trial);
    assign rem_d  = sq_ge ? RW'(rem_sh - trial) : RW'(rem_sh);

    // The dividend 2^K has a single set bit, fed in on the first divide step.
    logic [HW:0]   dsh;
    logic          div_ge;
    logic [HW-1:0] drem_d;
    logic [QW-1:0] quo_d;

    assign dsh    = {drem_q, (cnt_q == '0)};
    assign div_ge = (dsh >= {1'b0, root_q});
    assign drem_d = div_ge ? HW'(dsh - {1'b0, root_q}) : HW'(dsh);
    assign quo_d  = {quo_q, div_ge};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            out_vld_q <= 1'b0;
            out_dat_q <= '0;
            ovf_q     <= 1'b0;
        end else if (clr) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            out_vld_q <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            if (drop) ovf_q <= 1'b1;
            case (state_q)
                IDLE: if (pop) state_q <= LOAD;
                LOAD: begin
                    cnt_q   <= '0;
                    state_q <= SQRT;
                end
                SQRT: begin
                    if (cnt_q == CNT_W'(HW - 1)) begin
                        cnt_q   <= '0;
                        state_q <= DIV;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                DIV: begin
                    if (cnt_q == CNT_W'(QW - 1)) begin
                        state_q   <= OUT;
                        out_vld_q <= 1'b1;
                        out_dat_q <= sat_q(quo_d);
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                OUT: begin
                    if (out_rdy) begin
                        state_q   <= IDLE;
                        out_vld_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (pop) op_q <= head;
        case (state_q)
            LOAD: begin
                sh_q   <= v_prep;
                rem_q  <= '0;
                root_q <= '0;
            end
            SQRT: begin
                sh_q   <= {sh_q[IN_DW-3:0], 2'b00};
                rem_q  <= rem_d;
                root_q <= {root_q[HW-2:0], sq_ge};
                drem_q <= '0;
            end
            DIV: begin
                drem_q <= drem_d;
                quo_q  <= quo_d[QW-2:0];
            end
            default: ;
        endcase
    end

    assign out_vld = out_vld_q;
    assign out_dat = out_dat_q;
    assign ovf     = ovf_q;

endmodule

// File: tb/tb_ln_var_rsqrt.sv
// tb/tb_ln_var_rsqrt.sv - self-checking bench for ln_var_rsqrt with a behavioural reference
module tb_ln_var_rsqrt;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        clr;
    logic        in_vld;
    logic [39:0] in_dat;
    logic        out_vld;
    logic        out_rdy;
    logic [15:0] out_dat;
    logic        ovf;

    int total = 0;
    int bad   = 0;
    longint unsigned got_q[$];
    longint unsigned exp_q[$];

    always #5 clk = ~clk;

    ln_var_rsqrt dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (clr),
        .in_vld  (in_vld),
        .in_dat  (in_dat),
        .out_vld (out_vld),
        .out_rdy (out_rdy),
        .out_dat (out_dat),
        .ovf     (ovf)
    );

    always @(negedge clk) begin
        if (out_vld === 1'b1 && out_rdy === 1'b1) got_q.push_back(longint'(out_dat));
    end

    function automatic longint unsigned ref_rsqrt(input logic [39:0] d);
        longint unsigned v, lo, hi, mid, q;
        v  = d[39] ? 64'd1 : longint'(d) + 64'd1;
        lo = 1;
        hi = 64'd1 << 20;
        while (lo < hi) begin
            mid = (lo + hi + 1) / 2;
            if (mid * mid <= v) lo = mid;
            else hi = mid - 1;
        end
        q = 64'd65536 / lo;
        return (q > 64'd65535) ? 64'd65535 : q;
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_one(input logic [39:0] d);
        in_vld = 1'b1;
        in_dat = d;
        tick();
        in_vld = 1'b0;
    endtask

    task automatic wait_out(output int n);
        n = 1;
        while (out_vld !== 1'b1 && n < 400) begin
            tick();
            n++;
        end
    endtask

    logic [39:0] dir_dat [5];
    longint unsigned dir_exp [5];

    initial begin
        int n;
        int sent;
        logic [63:0] w;
        logic [63:0] tmp;
        logic [15:0] d0;
        logic stable;

        dir_dat = '{40'd0, 40'd255, 40'hFF_FFFF_FFFB, 40'h7F_FFFF_FFFF, 40'd3};
        dir_exp = '{65535, 4096, 65535, 0, 32768};

        rst_n = 1'b1; clr = 1'b0; in_vld = 1'b0; in_dat = '0; out_rdy = 1'b1;
        #2 rst_n = 1'b0;
        #3;
        check("rst_out_vld", out_vld, 0);
        check("rst_out_dat", out_dat, 0);
        check("rst_ovf", ovf, 0);
        tick(); tick();
        rst_n = 1'b1;
        tick(); tick();

        for (int i = 0; i < 5; i++) begin
            send_one(dir_dat[i]);
            wait_out(n);
            check($sformatf("latency_%0d", i), n, 39);
            check($sformatf("value_%0d", i), out_dat, dir_exp[i]);
            tick();
            check($sformatf("held_one_%0d", i), out_vld, 0);
        end

        got_q.delete();
        exp_q.delete();
        sent = 0;
        for (int c = 0; c < 4000 && sent < 25; c++) begin
            out_rdy = ($urandom_range(0, 3) != 0);
            if (sent - got_q.size() < 8 && $urandom_range(0, 9) == 0) begin
                w = {$urandom(), $urandom()};
                tmp = w >> $urandom_range(0, 40);
                in_vld = 1'b1;
                in_dat = tmp[39:0];
                exp_q.push_back(ref_rsqrt(tmp[39:0]));
                sent++;
            end else begin
                in_vld = 1'b0;
            end
            tick();
        end
        in_vld = 1'b0;
        out_rdy = 1'b1;
        for (int c = 0; c < 3000 && got_q.size() < sent; c++) tick();
        check("rnd_count", got_q.size(), sent);
        for (int i = 0; i < got_q.size() && i < exp_q.size(); i++)
            check($sformatf("rnd_%0d", i), got_q[i], exp_q[i]);
        check("rnd_no_ovf", ovf, 0);

        got_q.delete();
        out_rdy = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            in_vld = 1'b1;
            in_dat = 40'(i);
            tick();
        end
        in_vld = 1'b0;
        check("ovf_set", ovf, 1);
        wait_out(n);
        d0 = out_dat;
        stable = 1'b1;
        for (int i = 0; i < 6; i++) begin
            tick();
            if (out_vld !== 1'b1 || out_dat !== d0) stable = 1'b0;
        end
        check("stall_stable", stable, 1);
        check("stall_value", d0, ref_rsqrt(40'd1));
        out_rdy = 1'b1;
        for (int c = 0; c < 1000 && got_q.size() < 9; c++) tick();
        for (int c = 0; c < 100; c++) tick();
        check("ovf_count", got_q.size(), 9);
        for (int i = 0; i < got_q.size() && i < 9; i++)
            check($sformatf("ovf_order_%0d", i), got_q[i], ref_rsqrt(40'(i + 1)));

        got_q.delete();
        for (int i = 0; i < 3; i++) begin
            in_vld = 1'b1;
            in_dat = 40'(100 * (i + 1));
            tick();
        end
        in_vld = 1'b0;
        tick(); tick(); tick();
        check("ovf_sticky", ovf, 1);
        clr = 1'b1;
        in_vld = 1'b1;
        in_dat = 40'd77;
        tick();
        clr = 1'b0;
        in_vld = 1'b0;
        check("clr_ovf", ovf, 0);
        check("clr_out_vld", out_vld, 0);
        for (int c = 0; c < 120; c++) tick();
        check("clr_no_output", got_q.size(), 0);
        send_one(40'd48);
        wait_out(n);
        check("clr_new_latency", n, 39);
        check("clr_new_value", out_dat, 9362);
        tick();

        got_q.delete();
        for (int i = 0; i < 10; i++) begin
            in_vld = 1'b1;
            in_dat = 40'(1000 + i);
            tick();
        end
        in_vld = 1'b0;
        for (int c = 0; c < 20; c++) tick();
        check("pre_rst_ovf", ovf, 1);
        check("pre_rst_out_vld", out_vld, 0);
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_out_vld", out_vld, 0);
        check("async_rst_out_dat", out_dat, 0);
        check("async_rst_ovf", ovf, 0);
        tick(); tick();
        rst_n = 1'b1;
        for (int c = 0; c < 200; c++) tick();
        check("post_rst_no_output", got_q.size(), 0);
        check("post_rst_out_vld", out_vld, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
